// File: rtl/sam_pkg.sv
// Shared defaults and state encoding for the stream arbiter.
package sam_pkg;
    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 16;
    localparam int SRC_W_DEF     = $clog2(N_REQ_DEF);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/sam_rr_pick.sv
// Combinational round-robin pick: first set request after last_grant, wrapping.
module sam_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] winner,
    output logic         any
);
    int w_idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        w_idx  = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(last_grant) + k) % N;
            if (!any && req[w_idx]) begin
                winner = W'(w_idx);
                any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sam_stream_arb.sv
// N-to-1 packet stream arbiter: round-robin grants, bursts bounded by MAX_BURST,
// one registered output stage with valid/ready backpressure.
module sam_stream_arb
    import sam_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    localparam int SRC_W    = $clog2(N_REQ),
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ-1:0]        in_last,
    output logic [N_REQ-1:0]        in_ready,
    input  logic [N_REQ-1:0]        cfg_mask,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic [SRC_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);
    state_t             r_state;
    logic [SRC_W-1:0]   r_grant;
    logic [SRC_W-1:0]   r_last_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_last;
    logic [SRC_W-1:0]   r_out_src;

    logic [N_REQ-1:0]   w_req;
    logic [SRC_W-1:0]   w_win;
    logic               w_any;
    logic               w_slot;
    logic               w_acc;
    logic               w_done;
    logic [DATA_W-1:0]  w_beat;

    assign w_req = in_valid & cfg_mask;

    sam_rr_pick #(.N(N_REQ), .W(SRC_W)) u_pick (
        .req        (w_req),
        .last_grant (r_last_grant),
        .winner     (w_win),
        .any        (w_any)
    );

    // The output register can take a beat when empty or being drained this cycle.
    assign w_slot = out_ready | ~r_out_valid;
    assign w_acc  = (r_state == ST_GRANT) && in_valid[r_grant] && w_slot;
    assign w_done = w_acc && (in_last[r_grant] || (r_cnt == CNT_W'(MAX_BURST - 1)));
    assign w_beat = in_data[int'(r_grant)*DATA_W +: DATA_W];

    always_comb begin
        in_ready = '0;
        if (r_state == ST_GRANT)
            in_ready[r_grant] = w_slot;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= SRC_W'(N_REQ - 1);
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_cnt   <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                default: begin
                    // Mask and valid are ignored here: only last or burst limit ends a grant.
                    if (w_acc)
                        r_cnt <= r_cnt + 1'b1;
                    if (w_done) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= '0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_beat;
            r_out_last  <= in_last[r_grant];
            r_out_src   <= r_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;
    assign busy      = (r_state == ST_GRANT);
endmodule
